// File: rtl/ecg_class_vote.sv
// ecg_class_vote
// Post-classifier smoothing stage for per-beat ECG class labels. It keeps a
// sliding window of the last WIN labels and emits a majority-vote class for
// every accepted beat. It also drives an arrhythmia alarm with hysteresis.
//
// Optional feature macro: ECG_VOTE_FULL_ONLY_EN
//   When this macro is defined, votes and alarm evaluation are suppressed
//   until the window holds WIN labels.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    class label valid
//   in_class    label from the classifier
//   in_ready    stage can accept a label (registered)
//   vote_valid  vote result valid
//   vote_ready  downstream accepts the vote
//   vote_class  majority label over the window; ties go to the lowest index
//   vote_count  occurrences of vote_class in the window
//   fill        number of labels currently in the window (0..WIN)
//   alarm       abnormal-rhythm alarm with set/clear hysteresis
//   err_class   sticky flag: an illegal label was received
module ecg_class_vote #(
  parameter int NUM_CLASS = 5,
  parameter int WIN       = 8,
  parameter int ALARM_TH  = 3,
  parameter int ALARM_CLR = 1,
  parameter int CNT_W     = $clog2(WIN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2:0]       in_class,
  output logic             in_ready,
  output logic             vote_valid,
  input  logic             vote_ready,
  output logic [2:0]       vote_class,
  output logic [CNT_W-1:0] vote_count,
  output logic [CNT_W-1:0] fill,
  output logic             alarm,
  output logic             err_class
);

`ifdef ECG_VOTE_FULL_ONLY_EN
  localparam bit FULL_ONLY = 1'b1;
`else
  localparam bit FULL_ONLY = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, VOTE, HOLD} state_t;

  state_t           state;
  // hist[0] is the newest label and hist[WIN-1] is the oldest label.
  logic [2:0]       hist [WIN];
  logic [CNT_W-1:0] cnt  [NUM_CLASS];

  logic             full;
  logic             legal;
  logic [2:0]       oldest;
  logic [2:0]       best_idx;
  logic [CNT_W-1:0] best_cnt;
  logic [CNT_W-1:0] abnormal;

  assign full   = (fill == CNT_W'(WIN));
  assign legal  = (int'(in_class) < NUM_CLASS);
  assign oldest = hist[WIN-1];

  // The argmax uses a strict greater-than, so a tie keeps the lowest index.
  // The same loop sums the abnormal classes (1..NUM_CLASS-1).
  always_comb begin
    best_idx = '0;
    best_cnt = cnt[0];
    abnormal = '0;
    for (int k = 1; k < NUM_CLASS; k++) begin
      if (cnt[k] > best_cnt) begin
        best_cnt = cnt[k];
        best_idx = 3'(k);
      end
      abnormal = abnormal + cnt[k];
    end
  end

  // Control FSM, window storage and all registered outputs.
  // When the window is full, a push evicts hist[WIN-1]. If the pushed label
  // and the evicted label are the same class, the +1 and -1 cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      vote_valid <= 1'b0;
      vote_class <= '0;
      vote_count <= '0;
      fill       <= '0;
      alarm      <= 1'b0;
      err_class  <= 1'b0;
      for (int k = 0; k < WIN; k++) hist[k] <= '0;
      for (int k = 0; k < NUM_CLASS; k++) cnt[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            if (legal) begin
              for (int k = WIN - 1; k > 0; k--) hist[k] <= hist[k-1];
              hist[0] <= in_class;
              for (int k = 0; k < NUM_CLASS; k++) begin
                if ((in_class == 3'(k)) && !(full && (oldest == 3'(k))))
                  cnt[k] <= cnt[k] + CNT_W'(1);
                else if (!(in_class == 3'(k)) && full && (oldest == 3'(k)))
                  cnt[k] <= cnt[k] - CNT_W'(1);
              end
              if (!full) fill <= fill + CNT_W'(1);
              in_ready <= 1'b0;
              state    <= VOTE;
            end else begin
              err_class <= 1'b1;
            end
          end
        end
        VOTE: begin
          if (FULL_ONLY && !full) begin
            in_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            vote_class <= best_idx;
            vote_count <= best_cnt;
            if (int'(abnormal) >= ALARM_TH)
              alarm <= 1'b1;
            else if (int'(abnormal) <= ALARM_CLR)
              alarm <= 1'b0;
            vote_valid <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (vote_ready) begin
            vote_valid <= 1'b0;
            in_ready   <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecg_class_vote.sv
// tb_ecg_class_vote
// Directed self-checking bench for ecg_class_vote with default parameters
// (WIN=8, NUM_CLASS=5, ALARM_TH=3, ALARM_CLR=1). Inputs are driven and
// outputs are sampled on the falling clock edge.
// The bench follows ECG_VOTE_FULL_ONLY_EN so that its expectations match
// the build.
module tb_ecg_class_vote;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [2:0] in_class = '0;
  logic       in_ready;
  logic       vote_valid;
  logic       vote_ready = 1'b1;
  logic [2:0] vote_class;
  logic [3:0] vote_count;
  logic [3:0] fill;
  logic       alarm;
  logic       err_class;

  int tests_run = 0;
  int tests_failed = 0;

  ecg_class_vote dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_class   (in_class),
    .in_ready   (in_ready),
    .vote_valid (vote_valid),
    .vote_ready (vote_ready),
    .vote_class (vote_class),
    .vote_count (vote_count),
    .fill       (fill),
    .alarm      (alarm),
    .err_class  (err_class)
  );

  always #5 clk = ~clk;

  // A single comparison. The counters that the summary line prints are
  // updated here.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Applies reset for one clock and then releases it.
  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    vote_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Sends one label with vote_ready high. It then checks fill after
  // acceptance, the vote one cycle later, and the return to IDLE.
  task automatic applyStimulus(input string tag, input logic [2:0] lbl,
                               input int exp_class, input int exp_count,
                               input int exp_fill, input int exp_alarm);
    checkOutput({tag, " in_ready pre"}, 32'(in_ready), 1);
    in_valid = 1'b1;
    in_class = lbl;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput({tag, " fill"}, 32'(fill), 32'(exp_fill));
    checkOutput({tag, " no early vote"}, 32'(vote_valid), 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, " vote_valid"}, 32'(vote_valid), 1);
    checkOutput({tag, " vote_class"}, 32'(vote_class), 32'(exp_class));
    checkOutput({tag, " vote_count"}, 32'(vote_count), 32'(exp_count));
    checkOutput({tag, " alarm"}, 32'(alarm), 32'(exp_alarm));
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, " vote_valid 1 cycle"}, 32'(vote_valid), 0);
    checkOutput({tag, " in_ready post"}, 32'(in_ready), 1);
  endtask

  initial begin
    // Check the reset values during reset and the in_ready release after it.
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst in_ready", 32'(in_ready), 0);
    checkOutput("rst vote_valid", 32'(vote_valid), 0);
    checkOutput("rst vote_class", 32'(vote_class), 0);
    checkOutput("rst vote_count", 32'(vote_count), 0);
    checkOutput("rst fill", 32'(fill), 0);
    checkOutput("rst alarm", 32'(alarm), 0);
    checkOutput("rst err_class", 32'(err_class), 0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("post rst in_ready", 32'(in_ready), 1);

`ifdef ECG_VOTE_FULL_ONLY_EN
    // Full-only mode: no vote for the first 7 labels, then a vote on the 8th.
    for (int i = 1; i <= 7; i++) begin
      in_valid = 1'b1;
      in_class = 3'd0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput($sformatf("fo%0d fill", i), 32'(fill), 32'(i));
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("fo%0d no vote", i), 32'(vote_valid), 0);
      checkOutput($sformatf("fo%0d in_ready", i), 32'(in_ready), 1);
    end
    applyStimulus("fo8", 3'd0, 0, 8, 8, 0);
    applyStimulus("fo9", 3'd1, 0, 7, 8, 0);
`else
    // Fill the window with eight labels of class 0.
    for (int i = 1; i <= 8; i++)
      applyStimulus($sformatf("fill%0d", i), 3'd0, 0, i, i, 0);

    // Tie: a 1 followed by a 2 gives class 1 (lowest index).
    doReset();
    applyStimulus("tie a", 3'd1, 1, 1, 1, 0);
    applyStimulus("tie b", 3'd2, 1, 1, 2, 0);

    // Wrap: eight 0s, then eight 2s push the 0s out.
    doReset();
    for (int i = 1; i <= 8; i++)
      applyStimulus($sformatf("wrap0_%0d", i), 3'd0, 0, i, i, 0);
    for (int j = 1; j <= 8; j++) begin
      // There are j 2s and 8-j 0s in the window. The tie at j=4 goes to class 0.
      // abnormal = j, so the alarm sets at j=3.
      applyStimulus($sformatf("wrap2_%0d", j), 3'd2,
                    (j <= 4) ? 0 : 2, (j <= 4) ? 8 - j : j, 8, (j >= 3) ? 1 : 0);
    end

    // Alarm hysteresis test.
    doReset();
    applyStimulus("hy 0", 3'd0, 0, 1, 1, 0);
    applyStimulus("hy 1a", 3'd1, 0, 1, 2, 0);
    applyStimulus("hy 1b", 3'd1, 1, 2, 3, 0);
    applyStimulus("hy 1c", 3'd1, 1, 3, 4, 1);
    applyStimulus("hy z1", 3'd0, 1, 3, 5, 1);
    applyStimulus("hy z2", 3'd0, 0, 3, 6, 1);
    applyStimulus("hy z3", 3'd0, 0, 4, 7, 1);
    applyStimulus("hy z4", 3'd0, 0, 5, 8, 1);
    applyStimulus("hy z5", 3'd0, 0, 5, 8, 1);
    applyStimulus("hy z6", 3'd0, 0, 6, 8, 1);
    applyStimulus("hy z7", 3'd0, 0, 7, 8, 0);

    // Back-pressure: the vote is held for 10 cycles while a label is offered.
    doReset();
    vote_ready = 1'b0;
    in_valid = 1'b1;
    in_class = 3'd1;
    @(posedge clk);
    @(negedge clk);
    in_class = 3'd2;
    @(posedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput($sformatf("bp%0d vote_valid", c), 32'(vote_valid), 1);
      checkOutput($sformatf("bp%0d vote_class", c), 32'(vote_class), 1);
      checkOutput($sformatf("bp%0d vote_count", c), 32'(vote_count), 1);
      checkOutput($sformatf("bp%0d in_ready", c), 32'(in_ready), 0);
      checkOutput($sformatf("bp%0d fill", c), 32'(fill), 1);
    end
    in_valid = 1'b0;
    vote_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp release vote_valid", 32'(vote_valid), 0);
    checkOutput("bp release in_ready", 32'(in_ready), 1);
    checkOutput("bp offered not taken", 32'(fill), 1);

    // Illegal label 6: err_class sets, no vote, fill unchanged.
    in_valid = 1'b1;
    in_class = 3'd6;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("ill err_class", 32'(err_class), 1);
    checkOutput("ill fill", 32'(fill), 1);
    checkOutput("ill in_ready", 32'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("ill no vote", 32'(vote_valid), 0);
    checkOutput("ill err sticky", 32'(err_class), 1);

    // Reset while in HOLD.
    vote_ready = 1'b0;
    in_valid = 1'b1;
    in_class = 3'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rh vote_valid before", 32'(vote_valid), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vote_ready = 1'b1;
    checkOutput("rh vote_valid", 32'(vote_valid), 0);
    checkOutput("rh in_ready", 32'(in_ready), 0);
    checkOutput("rh vote_class", 32'(vote_class), 0);
    checkOutput("rh vote_count", 32'(vote_count), 0);
    checkOutput("rh fill", 32'(fill), 0);
    checkOutput("rh alarm", 32'(alarm), 0);
    checkOutput("rh err_class", 32'(err_class), 0);
    @(posedge clk);
    @(negedge clk);
    applyStimulus("rh next", 3'd4, 4, 1, 1, 0);

    // Boundary: label 5 equals NUM_CLASS and is illegal.
    in_valid = 1'b1;
    in_class = 3'd5;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("ill5 err_class", 32'(err_class), 1);
    checkOutput("ill5 fill", 32'(fill), 1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("ill5 no vote", 32'(vote_valid), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
